// File: rtl/regfiletmp_pkg.sv
// Shared types and constants for the speculative temporary register file controller.
package regfiletmp_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned EW    = 73;

    // Bit offsets of the fields read back from the head entry
    localparam int unsigned F_VALID    = 0;
    localparam int unsigned F_SVALID   = 1;
    localparam int unsigned F_SDATA_LO = 2;
    localparam int unsigned F_TYPE_LO  = 34;
    localparam int unsigned F_PC_LO    = 36;
    localparam int unsigned F_RD_LO    = 68;

    typedef enum logic [1:0] {
        IT_ALU    = 2'd0,
        IT_LOAD   = 2'd1,
        IT_STORE  = 2'd2,
        IT_BRANCH = 2'd3
    } inst_type_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SCRUB = 1'b1
    } fsm_e;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] pc;
        logic [1:0]    itype;
        logic [DW-1:0] spec_data;
        logic          spec_valid;
        logic          valid;
    } entry_t;

endpackage

// File: rtl/regfiletmp_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_c_o
);

    logic last_q;

    always_comb begin
        gnt_c_o = req_i;
        if (req_i == 2'b11) begin
            gnt_c_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Only a grant that is actually consumed moves the priority pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (advance_i && (req_i != 2'b00)) begin
            last_q <= gnt_c_o[1];
        end
    end

endmodule

// File: rtl/regfiletmp_ctrl.sv
// Write-port / head-port controller for the 32-entry speculative temp register file:
// circular allocation, arbitrated writeback, in-order retire and post-flush scrub.
module regfiletmp_ctrl
    import regfiletmp_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          disp_valid,
    output logic          disp_ready,
    input  logic [AW-1:0] disp_rd,
    input  logic [DW-1:0] disp_pc,
    input  logic [1:0]    disp_type,
    output logic [AW-1:0] disp_tag,
    input  logic          wb0_valid,
    input  logic [AW-1:0] wb0_tag,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic [AW-1:0] wb1_tag,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    output logic [EW-1:0] rf_data_in,
    output logic [AW-1:0] rf_waddr,
    output logic          rf_new_entry,
    output logic          rf_update_entry,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [EW-1:0] rf_rd_data,
    output logic          cm_valid,
    output logic [AW-1:0] cm_rd,
    output logic [DW-1:0] cm_data,
    output logic [DW-1:0] cm_pc,
    input  logic          cm_ready,
    output logic [CW-1:0] count
);

    fsm_e          fsm_q, fsm_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] scrub_q, scrub_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    wb_req;
    logic [1:0]    wb_gnt;
    logic          arb_adv;
    logic          disp_fire;
    logic          ret_fire;
    entry_t        wr_e;
    logic          unused_head_type;

    assign wb_req  = {wb1_valid, wb0_valid};
    assign arb_adv = (fsm_q == ST_RUN) && !flush;

    rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_i     (wb_req),
        .advance_i (arb_adv),
        .gnt_c_o   (wb_gnt)
    );

    assign disp_tag         = tail_q;
    assign rf_rd_addr       = head_q;
    assign count            = count_q;
    assign rf_data_in       = wr_e;
    assign cm_rd            = rf_rd_data[F_RD_LO +: AW];
    assign cm_pc            = rf_rd_data[F_PC_LO +: DW];
    assign cm_data          = rf_rd_data[F_SDATA_LO +: DW];
    assign unused_head_type = ^rf_rd_data[F_TYPE_LO +: 2];

    always_comb begin
        fsm_d           = fsm_q;
        head_d          = head_q;
        tail_d          = tail_q;
        scrub_d         = scrub_q;
        count_d         = count_q;
        wr_e            = '0;
        rf_waddr        = '0;
        rf_new_entry    = 1'b0;
        rf_update_entry = 1'b0;
        disp_ready      = 1'b0;
        cm_valid        = 1'b0;
        wb0_ready       = 1'b0;
        wb1_ready       = 1'b0;
        disp_fire       = 1'b0;
        ret_fire        = 1'b0;

        case (fsm_q)
            ST_RUN: begin
                disp_ready = (count_q < CW'(DEPTH)) && !wb0_valid && !wb1_valid && !flush;
                cm_valid   = (count_q != '0) && rf_rd_data[F_VALID] && rf_rd_data[F_SVALID] && !flush;
                // Writeback owns the port whenever one is pending
                if (!flush && (wb_req != 2'b00)) begin
                    rf_update_entry = 1'b1;
                    wr_e.spec_valid = 1'b1;
                    wb0_ready       = wb_gnt[0];
                    wb1_ready       = wb_gnt[1];
                    if (wb_gnt[1]) begin
                        rf_waddr       = wb1_tag;
                        wr_e.spec_data = wb1_data;
                    end else begin
                        rf_waddr       = wb0_tag;
                        wr_e.spec_data = wb0_data;
                    end
                end else if (disp_valid && disp_ready) begin
                    disp_fire    = 1'b1;
                    rf_new_entry = 1'b1;
                    rf_waddr     = tail_q;
                    wr_e.rd      = disp_rd;
                    wr_e.pc      = disp_pc;
                    wr_e.itype   = disp_type;
                    wr_e.valid   = 1'b1;
                    tail_d       = tail_q + AW'(1);
                end
                if (cm_valid && cm_ready) begin
                    ret_fire = 1'b1;
                    head_d   = head_q + AW'(1);
                end
                case ({disp_fire, ret_fire})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
            ST_SCRUB: begin
                // Writebacks are acknowledged but discarded while the file is wiped
                rf_new_entry = 1'b1;
                rf_waddr     = scrub_q;
                wb0_ready    = 1'b1;
                wb1_ready    = 1'b1;
                scrub_d      = scrub_q + AW'(1);
                if (scrub_q == AW'(DEPTH - 1)) begin
                    fsm_d = ST_RUN;
                end
            end
            default: fsm_d = ST_RUN;
        endcase

        if (flush) begin
            fsm_d   = ST_SCRUB;
            scrub_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            scrub_q <= '0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            scrub_q <= scrub_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_regfiletmp_ctrl.sv
// Bench for regfiletmp_ctrl: vector table for dispatch/writeback/retire, then
// directed sequences for full/wrap, simultaneous fire, flush scrub and reset-in-scrub.
module tb_regfiletmp_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [4:0]  disp_rd = '0;
    logic [31:0] disp_pc = '0;
    logic [1:0]  disp_type = '0;
    logic [4:0]  disp_tag;
    logic        wb0_valid = 1'b0;
    logic [4:0]  wb0_tag = '0;
    logic [31:0] wb0_data = '0;
    logic        wb0_ready;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb1_tag = '0;
    logic [31:0] wb1_data = '0;
    logic        wb1_ready;
    logic [72:0] rf_data_in;
    logic [4:0]  rf_waddr;
    logic        rf_new_entry;
    logic        rf_update_entry;
    logic [4:0]  rf_rd_addr;
    logic [72:0] rf_rd_data;
    logic        cm_valid;
    logic [4:0]  cm_rd;
    logic [31:0] cm_data;
    logic [31:0] cm_pc;
    logic        cm_ready = 1'b0;
    logic [5:0]  count;

    int passed = 0;
    int total  = 0;

    logic [72:0] mem [0:31];

    always #5 clock = ~clock;

    regfiletmp_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_pc(disp_pc), .disp_type(disp_type), .disp_tag(disp_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rf_data_in(rf_data_in), .rf_waddr(rf_waddr), .rf_new_entry(rf_new_entry),
        .rf_update_entry(rf_update_entry), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_pc(cm_pc),
        .cm_ready(cm_ready), .count(count)
    );

    // Behavioural temp register file: full writes and spec_data/spec_valid updates
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (rf_new_entry) begin
            mem[rf_waddr] <= rf_data_in;
        end else if (rf_update_entry) begin
            mem[rf_waddr][33:1] <= rf_data_in[33:1];
        end
    end
    assign rf_rd_data = mem[rf_rd_addr];

    function automatic logic [72:0] ent(input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] ty);
        return {rd, pc, ty, 32'h0, 1'b0, 1'b1};
    endfunction

    function automatic logic [72:0] upd(input logic [31:0] d);
        return {39'h0, d, 1'b1, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; disp_rd = '0; disp_pc = '0; disp_type = '0;
        wb0_valid = 1'b0; wb0_tag = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_tag = '0; wb1_data = '0; cm_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic dispatch(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            disp_valid = 1'b1; disp_rd = 5'(i); disp_pc = 32'h1000 + 32'(4 * i);
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic        flush, dv;
        logic [4:0]  drd;
        logic [31:0] dpc;
        logic [1:0]  dty;
        logic        w0v;
        logic [4:0]  w0t;
        logic [31:0] w0d;
        logic        w1v;
        logic [4:0]  w1t;
        logic [31:0] w1d;
        logic        cmr;
        logic        e_dr;
        logic [4:0]  e_tag;
        logic        e_new, e_upd;
        logic [4:0]  e_wa;
        logic [72:0] e_din;
        logic        e_cmv;
        logic [4:0]  e_cmrd;
        logic [31:0] e_cmd, e_cmpc;
        logic [5:0]  e_cnt;
        logic        e_w0r, e_w1r;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        // inputs: flush dv rd pc type | w0v tag data | w1v tag data | cm_ready
        // expect: disp_ready tag new upd waddr data_in | cm_valid rd data pc | count w0r w1r
        vecs[0]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd0,1'b0,1'b0,5'd0,73'h0, 1'b0,5'd0,32'h0,32'h0, 6'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,5'd1,32'h100,2'd1, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd0,1'b1,1'b0,5'd0,ent(5'd1,32'h100,2'd1), 1'b0,5'd0,32'h0,32'h0, 6'd0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,5'd2,32'h104,2'd2, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd1,1'b1,1'b0,5'd1,ent(5'd2,32'h104,2'd2), 1'b0,5'd0,32'h0,32'h0, 6'd1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,5'd3,32'h108,2'd3, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd2,1'b1,1'b0,5'd2,ent(5'd3,32'h108,2'd3), 1'b0,5'd0,32'h0,32'h0, 6'd2,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,5'd4,32'h10c,2'd0, 1'b1,5'd1,32'hAA, 1'b1,5'd0,32'h55, 1'b0,
                     1'b0,5'd3,1'b0,1'b1,5'd0,upd(32'h55), 1'b0,5'd0,32'h0,32'h0, 6'd3,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b1,5'd1,32'hAA, 1'b0,5'd0,32'h0, 1'b0,
                     1'b0,5'd3,1'b0,1'b1,5'd1,upd(32'hAA), 1'b1,5'd1,32'h55,32'h100, 6'd3,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd3,1'b0,1'b0,5'd0,73'h0, 1'b1,5'd1,32'h55,32'h100, 6'd3,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,
                     1'b1,5'd3,1'b0,1'b0,5'd0,73'h0, 1'b1,5'd1,32'h55,32'h100, 6'd3,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,
                     1'b1,5'd3,1'b0,1'b0,5'd0,73'h0, 1'b1,5'd2,32'hAA,32'h104, 6'd2,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b1,5'd2,32'h33, 1'b1,5'd2,32'h44, 1'b0,
                     1'b0,5'd3,1'b0,1'b1,5'd2,upd(32'h44), 1'b1,5'd2,32'hAA,32'h104, 6'd2,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,5'd0,32'h0,2'd0, 1'b1,5'd2,32'h33, 1'b1,5'd2,32'h44, 1'b0,
                     1'b0,5'd3,1'b0,1'b1,5'd2,upd(32'h33), 1'b1,5'd2,32'hAA,32'h104, 6'd2,1'b1,1'b0};

        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        for (int k = 0; k < NV; k++) begin
            flush = vecs[k].flush; disp_valid = vecs[k].dv; disp_rd = vecs[k].drd;
            disp_pc = vecs[k].dpc; disp_type = vecs[k].dty;
            wb0_valid = vecs[k].w0v; wb0_tag = vecs[k].w0t; wb0_data = vecs[k].w0d;
            wb1_valid = vecs[k].w1v; wb1_tag = vecs[k].w1t; wb1_data = vecs[k].w1d;
            cm_ready = vecs[k].cmr;
            #1;
            chk($sformatf("v%0d.disp_ready", k), 73'(disp_ready), 73'(vecs[k].e_dr));
            chk($sformatf("v%0d.disp_tag", k), 73'(disp_tag), 73'(vecs[k].e_tag));
            chk($sformatf("v%0d.new", k), 73'(rf_new_entry), 73'(vecs[k].e_new));
            chk($sformatf("v%0d.upd", k), 73'(rf_update_entry), 73'(vecs[k].e_upd));
            chk($sformatf("v%0d.waddr", k), 73'(rf_waddr), 73'(vecs[k].e_wa));
            chk($sformatf("v%0d.data_in", k), rf_data_in, vecs[k].e_din);
            chk($sformatf("v%0d.cm_valid", k), 73'(cm_valid), 73'(vecs[k].e_cmv));
            chk($sformatf("v%0d.count", k), 73'(count), 73'(vecs[k].e_cnt));
            chk($sformatf("v%0d.wb0_ready", k), 73'(wb0_ready), 73'(vecs[k].e_w0r));
            chk($sformatf("v%0d.wb1_ready", k), 73'(wb1_ready), 73'(vecs[k].e_w1r));
            if (vecs[k].e_cmv) begin
                chk($sformatf("v%0d.cm_rd", k), 73'(cm_rd), 73'(vecs[k].e_cmrd));
                chk($sformatf("v%0d.cm_data", k), 73'(cm_data), 73'(vecs[k].e_cmd));
                chk($sformatf("v%0d.cm_pc", k), 73'(cm_pc), 73'(vecs[k].e_cmpc));
            end
            tick();
        end

        // Fill to 32, retire while full, then allocation wraps to tag 0
        do_reset();
        for (int i = 0; i < 32; i++) begin
            idle();
            disp_valid = 1'b1; disp_rd = 5'(i); disp_pc = 32'h2000 + 32'(4 * i);
            #1;
            chk($sformatf("fill%0d.tag", i), 73'(disp_tag), 73'(i));
            chk($sformatf("fill%0d.ready", i), 73'(disp_ready), 73'd1);
            tick();
        end
        idle();
        disp_valid = 1'b1;
        #1;
        chk("full.disp_ready", 73'(disp_ready), 73'd0);
        chk("full.count", 73'(count), 73'd32);
        chk("full.new", 73'(rf_new_entry), 73'd0);
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h1234;
        #1;
        chk("full.wb_upd", 73'(rf_update_entry), 73'd1);
        chk("full.wb0_ready", 73'(wb0_ready), 73'd1);
        tick();
        idle();
        cm_ready = 1'b1;
        #1;
        chk("full.cm_valid", 73'(cm_valid), 73'd1);
        chk("full.cm_data", 73'(cm_data), 73'h1234);
        chk("full.cm_pc", 73'(cm_pc), 73'h2000);
        tick();
        idle();
        disp_valid = 1'b1; disp_rd = 5'd9; disp_pc = 32'h3000;
        #1;
        chk("wrap.count", 73'(count), 73'd31);
        chk("wrap.ready", 73'(disp_ready), 73'd1);
        chk("wrap.tag", 73'(disp_tag), 73'd0);
        chk("wrap.waddr", 73'(rf_waddr), 73'd0);
        tick();
        idle();
        #1;
        chk("wrap.count_after", 73'(count), 73'd32);

        // Dispatch and retire in the same cycle at count 5
        do_reset();
        dispatch(5);
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h7;
        tick();
        idle();
        disp_valid = 1'b1; disp_rd = 5'd20; disp_pc = 32'h4000; cm_ready = 1'b1;
        #1;
        chk("both.cm_valid", 73'(cm_valid), 73'd1);
        chk("both.ready", 73'(disp_ready), 73'd1);
        chk("both.tag", 73'(disp_tag), 73'd5);
        tick();
        idle();
        #1;
        chk("both.count", 73'(count), 73'd5);
        chk("both.tail", 73'(disp_tag), 73'd6);
        chk("both.head", 73'(rf_rd_addr), 73'd1);

        // Flush at count 10, then 32-cycle scrub
        do_reset();
        dispatch(10);
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h5A5A;
        tick();
        idle();
        flush = 1'b1; disp_valid = 1'b1; wb0_valid = 1'b1; wb0_tag = 5'd3; cm_ready = 1'b1;
        #1;
        chk("flush.ready", 73'(disp_ready), 73'd0);
        chk("flush.new", 73'(rf_new_entry), 73'd0);
        chk("flush.upd", 73'(rf_update_entry), 73'd0);
        chk("flush.cm_valid", 73'(cm_valid), 73'd0);
        chk("flush.wb0_ready", 73'(wb0_ready), 73'd0);
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            idle();
            disp_valid = 1'b1;
            if (i == 3) begin
                wb0_valid = 1'b1; wb0_tag = 5'd5; wb0_data = 32'h99;
                wb1_valid = 1'b1; wb1_tag = 5'd6; wb1_data = 32'h98;
            end
            #1;
            chk($sformatf("scrub%0d.new", i), 73'(rf_new_entry), 73'd1);
            chk($sformatf("scrub%0d.waddr", i), 73'(rf_waddr), 73'(i));
            chk($sformatf("scrub%0d.data", i), rf_data_in, 73'h0);
            chk($sformatf("scrub%0d.ready", i), 73'(disp_ready), 73'd0);
            chk($sformatf("scrub%0d.count", i), 73'(count), 73'd0);
            if (i == 3) begin
                chk("scrub.wb0_ready", 73'(wb0_ready), 73'd1);
                chk("scrub.wb1_ready", 73'(wb1_ready), 73'd1);
                chk("scrub.no_upd", 73'(rf_update_entry), 73'd0);
            end
            tick();
        end
        idle();
        #1;
        chk("post_scrub.ready", 73'(disp_ready), 73'd1);
        chk("post_scrub.tag", 73'(disp_tag), 73'd0);
        chk("post_scrub.cm_valid", 73'(cm_valid), 73'd0);
        begin
            logic [72:0] acc;
            acc = '0;
            for (int j = 0; j < 32; j++) acc = acc | mem[j];
            chk("post_scrub.file_zero", acc, 73'h0);
        end

        // Reset asserted mid-scrub at index 7
        do_reset();
        dispatch(2);
        flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        #1;
        chk("rst_scrub.idx", 73'(rf_waddr), 73'd7);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_scrub.ready", 73'(disp_ready), 73'd1);
        chk("rst_scrub.count", 73'(count), 73'd0);
        chk("rst_scrub.new", 73'(rf_new_entry), 73'd0);
        disp_valid = 1'b1; disp_rd = 5'd4; disp_pc = 32'h500;
        #1;
        chk("rst_scrub.tag", 73'(disp_tag), 73'd0);
        chk("rst_scrub.disp_new", 73'(rf_new_entry), 73'd1);
        tick();
        idle();
        #1;
        chk("rst_scrub.count1", 73'(count), 73'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfiletmp_ctrl.md
Name: regfiletmp_ctrl

Overview:
- Controller that owns the single write port and the head read port of the 32-entry speculative temporary register file.
- Allocates entries in circular order for dispatched instructions.
- Arbitrates result writebacks from two functional units onto the update port, and retires entries in program order.
- Scrubs the whole file after a pipeline flush.
- Sits between the dispatch stage, the execution units and the architectural register file.

Parameters:
- DEPTH, 32, number of entries; must equal 2**AW.
- AW, 5, entry index width.
- DW, 32, data/PC width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- flush  in  1  mispredict flush pulse
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available and write port granted
- disp_rd  in  5  destination register
- disp_pc  in  32  instruction PC
- disp_type  in  2  instruction type
- disp_tag  out  5  allocated entry index (= tail)
- wb0_valid / wb1_valid  in  1  writeback request, unit 0/1
- wb0_tag / wb1_tag  in  5  target entry
- wb0_data / wb1_data  in  32  result
- wb0_ready / wb1_ready  out  1  writeback accepted this cycle
- rf_data_in  out  73  file write data
- rf_waddr  out  5  file write address
- rf_new_entry  out  1  full-entry write strobe
- rf_update_entry  out  1  spec_data/spec_valid write strobe
- rf_rd_addr  out  5  head read address
- rf_rd_data  in  73  head entry contents
- cm_valid  out  1  head entry ready to retire
- cm_rd  out  5  retiring destination (rf_rd_data[72:68])
- cm_data  out  32  retiring value (rf_rd_data[33:2])
- cm_pc  out  32  retiring PC (rf_rd_data[67:36])
- cm_ready  in  1  architectural file accepts retire
- count  out  6  occupied entries, 0..32

Behaviour:
- Entry layout: [72:68] rd, [67:36] PC, [35:34] type, [33:2] spec_data, [1] spec_valid, [0] valid.
- State: head, tail (AW bits, wrap 31->0), count (6 bits), rr_last (1 bit), fsm {RUN, SCRUB}, scrub_idx (AW bits).
- Reset: head=tail=count=0, rr_last=0, fsm=RUN. Resulting outputs: disp_ready=1 (no wb pending), all strobes=0, cm_valid=0, wb*_ready=0.
- All rf_* and handshake outputs are combinational from state and inputs; the file samples them at the same posedge (zero-latency write).
- At most one of rf_new_entry and rf_update_entry is asserted in any cycle.
- Write-port priority in RUN: writeback > dispatch.
  - Any wb*_valid: the arbiter picks one; rf_update_entry=1, rf_waddr=tag, rf_data_in[33:2]=data, [1]=1, all other bits 0.
  - Both valid: grant the unit != rr_last, then rr_last <= granted unit. One valid: grant it, rr_last <= that unit.
  - disp_ready = (fsm==RUN) && (count<DEPTH) && !wb0_valid && !wb1_valid && !flush.
  - Dispatch fire: rf_new_entry=1, rf_waddr=tail, rf_data_in={disp_rd, disp_pc, disp_type, 32'b0, 1'b0, 1'b1}; tail <= tail+1.
- Retire:
  - rf_rd_addr = head.
  - cm_valid = (fsm==RUN) && (count!=0) && rf_rd_data[0] && rf_rd_data[1] && !flush.
  - On cm_valid && cm_ready: head <= head+1.
- count: +1 on dispatch fire, -1 on retire fire, unchanged when both fire in the same cycle.
- Update to the head entry: visible to cm_valid on the following cycle.
- Full (count==32): disp_ready=0; retire still allowed. Empty: cm_valid=0 regardless of stale file contents.
- flush (any state):
  - Next state SCRUB, scrub_idx=0, head=tail=count=0.
  - In the flush cycle itself no dispatch, update or retire fires.
- SCRUB:
  - Each cycle rf_new_entry=1, rf_waddr=scrub_idx, rf_data_in=0; scrub_idx++.
  - After writing index 31, return to RUN. SCRUB lasts exactly 32 cycles.
  - During SCRUB: disp_ready=0, cm_valid=0, wb*_ready=1 with writes dropped (no update strobe).
  - flush during SCRUB restarts scrub at 0.
- Reset mid-operation: immediate return to reset values; file contents are cleared by the file's own reset.

Decomposition:
- regfiletmp_pkg holds:
  - entry width 73 and field bit offsets;
  - inst_type encodings;
  - fsm state enum;
  - DEPTH/AW constants.
- One sub-module: rr_arb2, a two-requester round-robin arbiter with a last-grant register. Write it generic enough for the later second-port variant.

Test Plan:
- Reset, then 3 dispatches (rd=1,2,3; pc=0x100,0x104,0x108) -> disp_tag 0,1,2; rf_new_entry each cycle; count=3; cm_valid=0.
- wb0 tag 1 data 0xAA and wb1 tag 0 data 0x55 same cycle, rr_last=0 -> wb1 granted first, wb0 next cycle; disp_ready=0 both cycles. Next cycle cm_valid=1, cm_rd=1, cm_data=0x55.
- Fill to 32 entries -> disp_ready=0. Complete and retire head -> count=31, next dispatch gets tag 0 (wrap).
- Dispatch fire and retire fire in the same cycle at count=5 -> count stays 5, head and tail both advance.
- flush at count=10 -> 32 zero-writes at addresses 0..31; wb requests during scrub acked but produce no rf_update_entry; disp_ready returns at cycle 33 with tag 0.
- Assert reset during SCRUB at scrub_idx=7 -> fsm=RUN, count=0, disp_ready=1 the cycle after reset release.
